// File: rtl/fp_cfg_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | fp_cfg_ctrl : shadow/active configuration bank controller for fp pipeline.  |
// | Optional macro FP_CFG_READBACK_EN adds a shadow/active field read port.     |
// | Revision : 1.0                                                              |
// +----------------------------------------------------------------------------+
module fp_cfg_ctrl #(
  parameter  int STAGES  = 8,
  parameter  int INPUTS  = 8,
  parameter  int CHOICES = 40,
  parameter  int LAT     = 16,
  localparam int CELLS   = INPUTS / 2,
  localparam int OP_W    = 4,
  localparam int ID_W    = 4,
  localparam int MX_W    = 8,
  localparam int VAL_W   = 16,
  localparam int PRED_W  = 3,
  localparam int BCH_W   = 1
) (
  input  logic                                     clk,
  input  logic                                     rst,
  input  logic                                     cfg_valid,
  output logic                                     cfg_ready,
  input  logic [2:0]                               cfg_stage,
  input  logic [1:0]                               cfg_cell,
  input  logic [3:0]                               cfg_field,
  input  logic [15:0]                              cfg_data,
  input  logic                                     commit_req,
  output logic                                     commit_busy,
  output logic                                     commit_done,
  output logic                                     cfg_err,
  input  logic                                     cfg_err_clr,
  input  logic [INPUTS-1:0]                        valid_in,
  output logic                                     in_hold,
`ifdef FP_CFG_READBACK_EN
  input  logic                                     rd_req,
  input  logic                                     rd_bank,
  output logic [15:0]                              rd_data,
  output logic                                     rd_valid,
`endif
  output logic [STAGES-1:0][CHOICES-1:0]           choice,
  output logic [CELLS-1:0][STAGES-1:0][OP_W-1:0]   kufpu1_opcode,
  output logic [CELLS-1:0][STAGES-1:0][ID_W-1:0]   kufpu1_id,
  output logic [CELLS-1:0][STAGES-1:0][MX_W-1:0]   kufpu1_metricX,
  output logic [CELLS-1:0][STAGES-1:0][VAL_W-1:0]  kufpu1_val,
  output logic [CELLS-1:0][STAGES-1:0][PRED_W-1:0] kufpu1_pred_op,
  output logic [CELLS-1:0][STAGES-1:0][OP_W-1:0]   kufpu2_opcode,
  output logic [CELLS-1:0][STAGES-1:0][ID_W-1:0]   kufpu2_id,
  output logic [CELLS-1:0][STAGES-1:0][MX_W-1:0]   kufpu2_metricX,
  output logic [CELLS-1:0][STAGES-1:0][VAL_W-1:0]  kufpu2_val,
  output logic [CELLS-1:0][STAGES-1:0][PRED_W-1:0] kufpu2_pred_op,
  output logic [CELLS-1:0][STAGES-1:0][OP_W-1:0]   bfpu1_opcode,
  output logic [CELLS-1:0][STAGES-1:0][BCH_W-1:0]  bfpu1_choice,
  output logic [CELLS-1:0][STAGES-1:0][OP_W-1:0]   bfpu2_opcode,
  output logic [CELLS-1:0][STAGES-1:0][BCH_W-1:0]  bfpu2_choice
);

  localparam int CNT_W = $clog2(LAT + 1);

  typedef struct packed {
    logic [OP_W-1:0]   k1_op;
    logic [ID_W-1:0]   k1_id;
    logic [MX_W-1:0]   k1_mx;
    logic [VAL_W-1:0]  k1_val;
    logic [PRED_W-1:0] k1_pred;
    logic [OP_W-1:0]   k2_op;
    logic [ID_W-1:0]   k2_id;
    logic [MX_W-1:0]   k2_mx;
    logic [VAL_W-1:0]  k2_val;
    logic [PRED_W-1:0] k2_pred;
    logic [OP_W-1:0]   b1_op;
    logic [BCH_W-1:0]  b1_ch;
    logic [OP_W-1:0]   b2_op;
    logic [BCH_W-1:0]  b2_ch;
  } cell_cfg_t;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_DRAIN = 2'd1,
    S_SWAP  = 2'd2
  } state_t;

  cell_cfg_t [STAGES-1:0][CELLS-1:0] shadow_q, active_q;
  logic [STAGES-1:0][CHOICES-1:0]    sh_choice_q, act_choice_q;

  state_t           state_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             ready_q, hold_q, busy_q, done_q, err_q;
  logic             wr_acc, wr_bad;

  assign wr_acc = cfg_valid & ready_q;
  assign wr_bad = (cfg_field == 4'd15) || (int'(cfg_stage) >= STAGES) ||
                  ((cfg_field == 4'd14) && (cfg_cell == 2'd3));

  // Shadow bank: host writes only; a commit never modifies it.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      shadow_q    <= '0;
      sh_choice_q <= '0;
    end else if (wr_acc && !wr_bad) begin
      case (cfg_field)
        4'd0:  shadow_q[cfg_stage][cfg_cell].k1_op   <= cfg_data[OP_W-1:0];
        4'd1:  shadow_q[cfg_stage][cfg_cell].k1_id   <= cfg_data[ID_W-1:0];
        4'd2:  shadow_q[cfg_stage][cfg_cell].k1_mx   <= cfg_data[MX_W-1:0];
        4'd3:  shadow_q[cfg_stage][cfg_cell].k1_val  <= cfg_data[VAL_W-1:0];
        4'd4:  shadow_q[cfg_stage][cfg_cell].k1_pred <= cfg_data[PRED_W-1:0];
        4'd5:  shadow_q[cfg_stage][cfg_cell].k2_op   <= cfg_data[OP_W-1:0];
        4'd6:  shadow_q[cfg_stage][cfg_cell].k2_id   <= cfg_data[ID_W-1:0];
        4'd7:  shadow_q[cfg_stage][cfg_cell].k2_mx   <= cfg_data[MX_W-1:0];
        4'd8:  shadow_q[cfg_stage][cfg_cell].k2_val  <= cfg_data[VAL_W-1:0];
        4'd9:  shadow_q[cfg_stage][cfg_cell].k2_pred <= cfg_data[PRED_W-1:0];
        4'd10: shadow_q[cfg_stage][cfg_cell].b1_op   <= cfg_data[OP_W-1:0];
        4'd11: shadow_q[cfg_stage][cfg_cell].b1_ch   <= cfg_data[BCH_W-1:0];
        4'd12: shadow_q[cfg_stage][cfg_cell].b2_op   <= cfg_data[OP_W-1:0];
        4'd13: shadow_q[cfg_stage][cfg_cell].b2_ch   <= cfg_data[BCH_W-1:0];
        4'd14: begin
          case (cfg_cell)
            2'd0:    sh_choice_q[cfg_stage][15:0]         <= cfg_data;
            2'd1:    sh_choice_q[cfg_stage][31:16]        <= cfg_data;
            2'd2:    sh_choice_q[cfg_stage][CHOICES-1:32] <= cfg_data[CHOICES-33:0];
            default: ;
          endcase
        end
        default: ;
      endcase
    end
  end

  // Idle-cycle counter: any lane activity restarts the drain window.
  always_comb begin
    cnt_d = cnt_q;
    if (|valid_in)
      cnt_d = '0;
    else if (cnt_q != CNT_W'(LAT))
      cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      active_q     <= '0;
      act_choice_q <= '0;
      ready_q      <= 1'b1;
      hold_q       <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (wr_acc && wr_bad)
        err_q <= 1'b1;
      else if (cfg_err_clr)
        err_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (commit_req) begin
            state_q <= S_DRAIN;
            cnt_q   <= '0;
            hold_q  <= 1'b1;
            busy_q  <= 1'b1;
            ready_q <= 1'b0;
          end
        end
        S_DRAIN: begin
          cnt_q <= cnt_d;
          if (cnt_d == CNT_W'(LAT))
            state_q <= S_SWAP;
        end
        S_SWAP: begin
          active_q     <= shadow_q;
          act_choice_q <= sh_choice_q;
          state_q      <= S_IDLE;
          cnt_q        <= '0;
          hold_q       <= 1'b0;
          busy_q       <= 1'b0;
          ready_q      <= 1'b1;
          done_q       <= 1'b1;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign cfg_ready   = ready_q;
  assign in_hold     = hold_q;
  assign commit_busy = busy_q;
  assign commit_done = done_q;
  assign cfg_err     = err_q;

  for (genvar s = 0; s < STAGES; s++) begin : g_stage
    assign choice[s] = act_choice_q[s];
    for (genvar c = 0; c < CELLS; c++) begin : g_cell
      assign kufpu1_opcode[c][s]  = active_q[s][c].k1_op;
      assign kufpu1_id[c][s]      = active_q[s][c].k1_id;
      assign kufpu1_metricX[c][s] = active_q[s][c].k1_mx;
      assign kufpu1_val[c][s]     = active_q[s][c].k1_val;
      assign kufpu1_pred_op[c][s] = active_q[s][c].k1_pred;
      assign kufpu2_opcode[c][s]  = active_q[s][c].k2_op;
      assign kufpu2_id[c][s]      = active_q[s][c].k2_id;
      assign kufpu2_metricX[c][s] = active_q[s][c].k2_mx;
      assign kufpu2_val[c][s]     = active_q[s][c].k2_val;
      assign kufpu2_pred_op[c][s] = active_q[s][c].k2_pred;
      assign bfpu1_opcode[c][s]   = active_q[s][c].b1_op;
      assign bfpu1_choice[c][s]   = active_q[s][c].b1_ch;
      assign bfpu2_opcode[c][s]   = active_q[s][c].b2_op;
      assign bfpu2_choice[c][s]   = active_q[s][c].b2_ch;
    end
  end

`ifdef FP_CFG_READBACK_EN
  cell_cfg_t          rd_cell;
  logic [CHOICES-1:0] rd_ch;
  logic [15:0]        rd_field, rd_data_q;
  logic               rd_valid_q;

  // Illegal addresses read back as zero without flagging an error.
  always_comb begin
    rd_cell  = rd_bank ? active_q[cfg_stage][cfg_cell] : shadow_q[cfg_stage][cfg_cell];
    rd_ch    = rd_bank ? act_choice_q[cfg_stage] : sh_choice_q[cfg_stage];
    rd_field = '0;
    if (!wr_bad) begin
      case (cfg_field)
        4'd0:  rd_field = 16'(rd_cell.k1_op);
        4'd1:  rd_field = 16'(rd_cell.k1_id);
        4'd2:  rd_field = 16'(rd_cell.k1_mx);
        4'd3:  rd_field = 16'(rd_cell.k1_val);
        4'd4:  rd_field = 16'(rd_cell.k1_pred);
        4'd5:  rd_field = 16'(rd_cell.k2_op);
        4'd6:  rd_field = 16'(rd_cell.k2_id);
        4'd7:  rd_field = 16'(rd_cell.k2_mx);
        4'd8:  rd_field = 16'(rd_cell.k2_val);
        4'd9:  rd_field = 16'(rd_cell.k2_pred);
        4'd10: rd_field = 16'(rd_cell.b1_op);
        4'd11: rd_field = 16'(rd_cell.b1_ch);
        4'd12: rd_field = 16'(rd_cell.b2_op);
        4'd13: rd_field = 16'(rd_cell.b2_ch);
        4'd14: begin
          case (cfg_cell)
            2'd0:    rd_field = rd_ch[15:0];
            2'd1:    rd_field = rd_ch[31:16];
            2'd2:    rd_field = 16'(rd_ch[CHOICES-1:32]);
            default: rd_field = '0;
          endcase
        end
        default: rd_field = '0;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      rd_valid_q <= rd_req;
      if (rd_req)
        rd_data_q <= rd_field;
    end
  end

  assign rd_data  = rd_data_q;
  assign rd_valid = rd_valid_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_fp_cfg_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_fp_cfg_ctrl : directed scoreboard bench for fp_cfg_ctrl.                  |
// | Revision : 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_fp_cfg_ctrl;
  localparam int LAT = 16;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic        cfg_valid = 1'b0, cfg_ready;
  logic [2:0]  cfg_stage = '0;
  logic [1:0]  cfg_cell  = '0;
  logic [3:0]  cfg_field = '0;
  logic [15:0] cfg_data  = '0;
  logic        commit_req = 1'b0, commit_busy, commit_done, cfg_err;
  logic        cfg_err_clr = 1'b0;
  logic [7:0]  valid_in = '0;
  logic        in_hold;
`ifdef FP_CFG_READBACK_EN
  logic        rd_req = 1'b0, rd_bank = 1'b0, rd_valid;
  logic [15:0] rd_data;
`endif
  logic [7:0][39:0]       choice;
  logic [3:0][7:0][3:0]   kufpu1_opcode, kufpu1_id, kufpu2_opcode, kufpu2_id;
  logic [3:0][7:0][7:0]   kufpu1_metricX, kufpu2_metricX;
  logic [3:0][7:0][15:0]  kufpu1_val, kufpu2_val;
  logic [3:0][7:0][2:0]   kufpu1_pred_op, kufpu2_pred_op;
  logic [3:0][7:0][3:0]   bfpu1_opcode, bfpu2_opcode;
  logic [3:0][7:0][0:0]   bfpu1_choice, bfpu2_choice;

  fp_cfg_ctrl dut (
    .clk(clk), .rst(rst),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .cfg_stage(cfg_stage), .cfg_cell(cfg_cell), .cfg_field(cfg_field), .cfg_data(cfg_data),
    .commit_req(commit_req), .commit_busy(commit_busy), .commit_done(commit_done),
    .cfg_err(cfg_err), .cfg_err_clr(cfg_err_clr),
    .valid_in(valid_in), .in_hold(in_hold),
`ifdef FP_CFG_READBACK_EN
    .rd_req(rd_req), .rd_bank(rd_bank), .rd_data(rd_data), .rd_valid(rd_valid),
`endif
    .choice(choice),
    .kufpu1_opcode(kufpu1_opcode), .kufpu1_id(kufpu1_id), .kufpu1_metricX(kufpu1_metricX),
    .kufpu1_val(kufpu1_val), .kufpu1_pred_op(kufpu1_pred_op),
    .kufpu2_opcode(kufpu2_opcode), .kufpu2_id(kufpu2_id), .kufpu2_metricX(kufpu2_metricX),
    .kufpu2_val(kufpu2_val), .kufpu2_pred_op(kufpu2_pred_op),
    .bfpu1_opcode(bfpu1_opcode), .bfpu1_choice(bfpu1_choice),
    .bfpu2_opcode(bfpu2_opcode), .bfpu2_choice(bfpu2_choice)
  );

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic [15:0] k1v12;   // kufpu1_val, cell 1 stage 2
    logic [39:0] ch7;     // choice word of stage 7
    logic [15:0] k2v53;   // kufpu2_val, cell 3 stage 5
    logic [3:0]  k1op00;  // kufpu1_opcode, cell 0 stage 0
  } exp_t;

  exp_t        sb[$];
  logic [15:0] m_k1v12 = '0, m_k2v53 = '0;
  logic [39:0] m_ch7   = '0;
  logic [3:0]  m_k1op00 = '0;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push_exp();
    exp_t e;
    e = '{m_k1v12, m_ch7, m_k2v53, m_k1op00};
    sb.push_back(e);
  endtask

  task automatic cfg_write(input logic [2:0] s, input logic [1:0] c, input logic [3:0] f,
                           input logic [15:0] d, input bit with_commit);
    cfg_valid  = 1'b1;
    cfg_stage  = s;
    cfg_cell   = c;
    cfg_field  = f;
    cfg_data   = d;
    commit_req = with_commit;
    step();
    cfg_valid  = 1'b0;
    commit_req = 1'b0;
    if (with_commit) push_exp();
  endtask

  // Counts edges from the commit-sampling edge until commit_done is seen, then scores.
  task automatic wait_commit(input string tag);
    int   k;
    exp_t e;
    k = 0;
    while (commit_done !== 1'b1 && k < 4 * LAT) begin
      step();
      k++;
    end
    check({tag, "_latency"}, 64'(k), 64'(LAT + 1));
    check({tag, "_sb_nonempty"}, 64'(sb.size() != 0), 64'd1);
    if (sb.size() != 0) e = sb.pop_front();
    else e = '{'0, '0, '0, '0};
    check({tag, "_k1val_c1s2"}, 64'(kufpu1_val[1][2]), 64'(e.k1v12));
    check({tag, "_choice_s7"}, 64'(choice[7]), 64'(e.ch7));
    check({tag, "_k2val_c3s5"}, 64'(kufpu2_val[3][5]), 64'(e.k2v53));
    check({tag, "_k1op_c0s0"}, 64'(kufpu1_opcode[0][0]), 64'(e.k1op00));
    step();
    check({tag, "_done_single"}, 64'(commit_done), 64'd0);
    check({tag, "_hold_released"}, 64'(in_hold), 64'd0);
  endtask

  initial begin
    bit seen_done;
    // Reset state
    repeat (2) step();
    rst = 1'b1;
    step();
    check("rst_ready", 64'(cfg_ready), 64'd1);
    check("rst_hold", 64'(in_hold), 64'd0);
    check("rst_busy", 64'(commit_busy), 64'd0);
    check("rst_done", 64'(commit_done), 64'd0);
    check("rst_err", 64'(cfg_err), 64'd0);
    check("rst_active_zero", 64'(|{choice, kufpu1_val, kufpu2_val, kufpu1_opcode, bfpu1_opcode,
                                    bfpu2_choice, kufpu1_metricX, kufpu2_pred_op}), 64'd0);

    // Basic write then commit with no traffic
    m_k1v12 = 16'hBEEF;
    cfg_write(3'd2, 2'd1, 4'd3, 16'hBEEF, 1'b0);
    check("pre_commit_active", 64'(kufpu1_val[1][2]), 64'd0);
    commit_req = 1'b1;
    step();
    commit_req = 1'b0;
    push_exp();
    check("drain_hold", 64'(in_hold), 64'd1);
    check("drain_busy", 64'(commit_busy), 64'd1);
    check("drain_ready", 64'(cfg_ready), 64'd0);
    wait_commit("basic");
    check("orient_c2s1_zero", 64'(kufpu1_val[2][1]), 64'd0);

    // Choice slices; last write shares its cycle with commit_req
    m_ch7 = 40'hA5_0000_FFFF;
    cfg_write(3'd7, 2'd0, 4'd14, 16'hFFFF, 1'b0);
    cfg_write(3'd7, 2'd1, 4'd14, 16'h0000, 1'b0);
    cfg_write(3'd7, 2'd2, 4'd14, 16'h01A5, 1'b1);
    wait_commit("choice");

    // Illegal writes and error flag priority
    cfg_write(3'd0, 2'd0, 4'd15, 16'h1234, 1'b0);
    check("err_field15", 64'(cfg_err), 64'd1);
    cfg_err_clr = 1'b1;
    cfg_write(3'd4, 2'd3, 4'd14, 16'hFFFF, 1'b0);
    check("err_set_beats_clr", 64'(cfg_err), 64'd1);
    step();
    cfg_err_clr = 1'b0;
    check("err_cleared", 64'(cfg_err), 64'd0);
    m_k1op00 = 4'hF;
    cfg_write(3'd0, 2'd0, 4'd0, 16'hFFFF, 1'b1);
    wait_commit("illegal");

    // Drain restart by lane activity at counter LAT-1
    m_k2v53 = 16'h1234;
    cfg_write(3'd5, 2'd3, 4'd8, 16'h1234, 1'b0);
    commit_req = 1'b1;
    step();
    commit_req = 1'b0;
    push_exp();
    repeat (LAT - 1) step();
    valid_in   = 8'b0000_1000;
    cfg_valid  = 1'b1;
    cfg_stage  = 3'd5;
    cfg_cell   = 2'd3;
    cfg_field  = 4'd8;
    cfg_data   = 16'hDEAD;
    commit_req = 1'b1;
    step();
    valid_in   = '0;
    cfg_valid  = 1'b0;
    commit_req = 1'b0;
    check("restart_ready_low", 64'(cfg_ready), 64'd0);
    check("restart_still_busy", 64'(commit_busy), 64'd1);
    wait_commit("restart");
    seen_done = 1'b0;
    for (int i = 0; i < LAT + 4; i++) begin
      step();
      if (commit_done) seen_done = 1'b1;
    end
    check("no_queued_commit", 64'(seen_done), 64'd0);

    // Asynchronous reset in the middle of a drain
    cfg_write(3'd2, 2'd1, 4'd3, 16'h7777, 1'b0);
    commit_req = 1'b1;
    step();
    commit_req = 1'b0;
    repeat (5) step();
    #2 rst = 1'b0;
    #1;
    check("arst_hold", 64'(in_hold), 64'd0);
    check("arst_busy", 64'(commit_busy), 64'd0);
    check("arst_ready", 64'(cfg_ready), 64'd1);
    check("arst_active_zero", 64'(|{choice, kufpu1_val, kufpu2_val, kufpu1_opcode}), 64'd0);
    #3 rst = 1'b1;
    seen_done = 1'b0;
    for (int i = 0; i < LAT + 4; i++) begin
      step();
      if (commit_done) seen_done = 1'b1;
    end
    check("arst_no_swap", 64'(seen_done), 64'd0);
    check("arst_active_stays_zero", 64'(|{choice, kufpu1_val, kufpu2_val}), 64'd0);

`ifdef FP_CFG_READBACK_EN
    cfg_write(3'd1, 2'd2, 4'd10, 16'h0005, 1'b0);
    rd_req  = 1'b1;
    rd_bank = 1'b0;
    step();
    check("rd_shadow_valid", 64'(rd_valid), 64'd1);
    check("rd_shadow_data", 64'(rd_data), 64'h5);
    rd_bank = 1'b1;
    step();
    check("rd_active_data", 64'(rd_data), 64'h0);
    rd_bank   = 1'b0;
    cfg_field = 4'd15;
    step();
    rd_req = 1'b0;
    check("rd_illegal_valid", 64'(rd_valid), 64'd1);
    check("rd_illegal_data", 64'(rd_data), 64'h0);
    check("rd_illegal_no_err", 64'(cfg_err), 64'd0);
    step();
    check("rd_valid_drop", 64'(rd_valid), 64'd0);
`endif

    check("sb_drained", 64'(sb.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
